// File: rtl/colordetc_pkg.sv
// colordetc_pkg: shared mode encodings, debouncer states and widths for the colour-detect controller
package colordetc_pkg;
  typedef enum logic [1:0] {
    MODE_G    = 2'b00,
    MODE_R    = 2'b01,
    MODE_B    = 2'b10,
    MODE_PASS = 2'b11
  } mode_t;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
  localparam int HIT_W = 20;
  function automatic mode_t next_mode(mode_t m);
    return mode_t'(m + 2'd1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: accepts a key level after DEBOUNCE_CYCLES consecutive equal samples; one-cycle press pulse
module key_debounce
  import colordetc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  deb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic press_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      press <= press_n;
    end
  end
  // The sample that leaves IDLE/HELD already counts as the first stable one
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    case (state)
      IDLE: if (!key_n) begin
        state_n = PRESS_WAIT;
        cnt_n   = CW'(1);
      end
      PRESS_WAIT: if (key_n) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (cnt == LAST) begin
        state_n = HELD;
        cnt_n   = '0;
        press_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      HELD: if (key_n) begin
        state_n = RELEASE_WAIT;
        cnt_n   = CW'(1);
      end
      RELEASE_WAIT: if (!key_n) begin
        state_n = HELD;
        cnt_n   = '0;
      end else if (cnt == LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/colordetc_ctrl.sv
// colordetc_ctrl: key-driven mode select applied at frame start, plus per-frame hit counter.
// Define COLORDETC_AUTO_CYCLE_EN to step the mode automatically every FRAMES_PER_STEP frames.
module colordetc_ctrl
  import colordetc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic             vsync,
  input  logic             pix_valid,
  input  logic             pix_hit,
  output logic [1:0]       ctrl,
  output logic             mode_pend,
  output logic [HIT_W-1:0] hit_count,
  output logic             hit_count_vld
);
  if (DEBOUNCE_CYCLES < 2 || FRAMES_PER_STEP < 1) begin : g_bad_param
    $error("colordetc_ctrl: DEBOUNCE_CYCLES must be >= 2 and FRAMES_PER_STEP >= 1");
  end
  logic [1:0] key_s, vs_s, vs_vld;
  logic vs_d, vs_edge, press, step, hit;
  mode_t ctrl_q, ctrl_n, pend, pend_n, base;
  logic [HIT_W-1:0] acc, acc_n;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_s[1]),
    .press (press)
  );
`ifdef COLORDETC_AUTO_CYCLE_EN
  localparam int FW = $clog2(FRAMES_PER_STEP + 1);
  logic [FW-1:0] fcnt;
  assign step = vs_edge && fcnt == FW'(FRAMES_PER_STEP - 1);
  always_ff @(posedge clk) begin
    if (rst || press || step) fcnt <= '0;
    else if (vs_edge) fcnt <= fcnt + 1'b1;
  end
`else
  assign step = 1'b0;
`endif
  // vs_vld marks real samples in the synchronizer; until then the previous level reads as high
  always_comb begin
    hit     = pix_valid & pix_hit;
    vs_edge = vs_vld[1] & vs_s[1] & ~vs_d;
    base    = step ? next_mode(pend) : pend;
    ctrl_n  = vs_edge ? base : ctrl_q;
    pend_n  = press ? next_mode(base) : base;
    acc_n   = vs_edge ? HIT_W'(hit) : (hit && acc != '1) ? acc + 1'b1 : acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s         <= 2'b11;
      vs_s          <= 2'b00;
      vs_vld        <= 2'b00;
      vs_d          <= 1'b1;
      ctrl_q        <= MODE_PASS;
      pend          <= MODE_PASS;
      mode_pend     <= 1'b0;
      hit_count     <= '0;
      hit_count_vld <= 1'b0;
      acc           <= '0;
    end else begin
      key_s         <= {key_s[0], key_n};
      vs_s          <= {vs_s[0], vsync};
      vs_vld        <= {vs_vld[0], 1'b1};
      vs_d          <= vs_vld[1] ? vs_s[1] : 1'b1;
      ctrl_q        <= ctrl_n;
      pend          <= pend_n;
      mode_pend     <= pend_n != ctrl_n;
      if (vs_edge) hit_count <= acc;
      hit_count_vld <= vs_edge;
      acc           <= acc_n;
    end
  end
  assign ctrl = ctrl_q;
endmodule

// File: tb/tb_colordetc_ctrl.sv
// tb_colordetc_ctrl: directed scenarios plus random traffic checked against a cycle-level behavioural model
module tb_colordetc_ctrl;
  localparam int D = 4;
  localparam int F = 3;
  localparam int MAXH = 20'hFFFFF;
`ifdef COLORDETC_AUTO_CYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, key_n = 1'b1, vsync = 1'b0, pix_valid = 1'b0, pix_hit = 1'b0;
  logic [1:0] ctrl;
  logic mode_pend, hit_count_vld;
  logic [19:0] hit_count;
  int vectors = 0, miscompares = 0, vld_seen = 0;
  int m_ctrl, m_pend, m_fcnt, m_hc, m_acc;
  bit m_vld, m_mp;
  bit held, press_q, k1, k2, v1, v2, v3;
  int low_run, high_run;

  colordetc_ctrl #(.DEBOUNCE_CYCLES(D), .FRAMES_PER_STEP(F)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .vsync(vsync), .pix_valid(pix_valid),
    .pix_hit(pix_hit), .ctrl(ctrl), .mode_pend(mode_pend), .hit_count(hit_count),
    .hit_count_vld(hit_count_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs seen at a clock edge; synchronizer history before reset release reads as idle
  // key and an already-high vsync, so no edge can come from pre-release levels.
  task automatic model_step(input bit r, input bit k0, input bit v0, input bit h);
    bit p, e, sk, step;
    int base;
    if (r) begin
      m_ctrl = 3; m_pend = 3; m_mp = 0; m_hc = 0; m_vld = 0; m_acc = 0; m_fcnt = 0;
      held = 0; low_run = 0; high_run = 0; press_q = 0;
      k1 = 1; k2 = 1; v1 = 1; v2 = 1; v3 = 1;
      return;
    end
    p = press_q; e = v2 && !v3; sk = k2;
    press_q = 0;
    if (!held) begin
      low_run = sk ? 0 : low_run + 1;
      if (low_run == D) begin held = 1; low_run = 0; press_q = 1; end
    end else begin
      high_run = sk ? high_run + 1 : 0;
      if (high_run == D) begin held = 0; high_run = 0; end
    end
    step = AUTO && e && m_fcnt == F - 1;
    base = step ? (m_pend + 1) % 4 : m_pend;
    if (e) m_ctrl = base;
    m_pend = (base + int'(p)) % 4;
    m_fcnt = (p || step) ? 0 : e ? m_fcnt + 1 : m_fcnt;
    m_mp = m_pend != m_ctrl;
    m_vld = e;
    if (e) begin m_hc = m_acc; m_acc = int'(h); end
    else if (m_acc < MAXH) m_acc += int'(h);
    k2 = k1; k1 = k0; v3 = v2; v2 = v1; v1 = v0;
  endtask

  task automatic tick();
    bit r0, k0, v0, h0;
    r0 = rst; k0 = key_n; v0 = vsync; h0 = pix_valid & pix_hit;
    @(posedge clk);
    model_step(r0, k0, v0, h0);
    #1;
    check("ctrl", int'(ctrl), m_ctrl);
    check("mode_pend", int'(mode_pend), int'(m_mp));
    check("hit_count", int'(hit_count), m_hc);
    check("hit_count_vld", int'(hit_count_vld), int'(m_vld));
    if (hit_count_vld) vld_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; run(2); rst = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b1; run(2); vsync = 1'b0; run(4);
  endtask

  task automatic press();
    key_n = 1'b0; run(8); key_n = 1'b1; run(8);
  endtask

  initial begin
    int key_left;
    vsync = 1'b1;
    run(3);
    check("reset_ctrl", int'(ctrl), 3);
    check("reset_hit_count", int'(hit_count), 0);
    rst = 1'b0;
    run(3);
    check("vsync_high_at_release", vld_seen, 0);
    vsync = 1'b0; run(3);
    frame();
    check("first_frame_vld", vld_seen, 1);
    check("first_frame_ctrl", int'(ctrl), 3);
    check("first_frame_hits", int'(hit_count), 0);

    key_n = 1'b0; run(3); key_n = 1'b1; run(8);
    check("short_press_pend", int'(mode_pend), 0);

    key_n = 1'b0; run(10); key_n = 1'b1; run(10);
    check("press_pend", int'(mode_pend), 1);
    vsync = 1'b1; run(2);
    check("ctrl_before_3", int'(ctrl), 3);
    run(1);
    check("ctrl_at_3", int'(ctrl), 0);
    vsync = 1'b0; run(3);
    check("pend_cleared", int'(mode_pend), 0);

    do_reset();
    repeat (3) press();
    frame();
    check("three_presses", int'(ctrl), 2);
    key_n = 1'b0; run(4); vsync = 1'b1; run(3);
    check("coincident_ctrl", int'(ctrl), 2);
    check("coincident_pend", int'(mode_pend), 1);
    key_n = 1'b1; vsync = 1'b0; run(10);

    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1; pix_hit = (i % 3) != 2; tick();
    end
    pix_valid = 1'b0; pix_hit = 1'b0;
    frame();
    check("hits_7", int'(hit_count), 7);
    check("hits_vld_once", vld_seen, 1);
    force dut.acc = 20'hFFFFA;
    #1 release dut.acc;
    m_acc = 20'hFFFFA;
    pix_valid = 1'b1; pix_hit = 1'b1; run(10);
    pix_valid = 1'b0; pix_hit = 1'b0;
    frame();
    check("hits_saturate", int'(hit_count), MAXH);

    if (AUTO) begin
      do_reset();
      repeat (2) frame();
      check("auto_edge2", int'(ctrl), 3);
      frame();
      check("auto_edge3", int'(ctrl), 0);
      repeat (3) frame();
      check("auto_edge6", int'(ctrl), 1);
      do_reset();
      repeat (2) frame();
      press();
      repeat (2) frame();
      check("auto_delay_edge4", int'(ctrl), 0);
      frame();
      check("auto_delay_edge5", int'(ctrl), 1);
    end

    key_left = 1;
    for (int c = 0; c < 4000; c++) begin
      if (--key_left == 0) begin
        key_n = ~key_n;
        key_left = int'($urandom_range(1, 10));
      end
      if ($urandom_range(0, 9) == 0) vsync = ~vsync;
      pix_valid = 1'($urandom_range(0, 1));
      pix_hit = 1'($urandom_range(0, 1));
      rst = $urandom_range(0, 799) == 0;
      tick();
    end
    rst = 1'b0;
    run(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
